spi_sample_target: RTL and testbench

// - SPI peripheral (target) side of the pedal's SPI sample link; the pedal's SPI master drives sclk/mosi and samples miso.
// - Used for on-chip loopback/self-test of the master.
// - Also lets an external MCU stream audio samples into the effect chain.
// - Mode 0 (CPOL=0, CPHA=0), MSB first, one WIDTH-bit word per chip-select frame.
// - All SPI inputs are oversampled in the single system clock domain; no logic runs on sclk.

---
 rtl/spi_sample_target_pkg.sv | 20 ++
 rtl/spi_sample_target_if.sv | 27 ++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_sample_target.sv | 149 ++++++++++++++
 tb/tb_spi_sample_target.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/spi_sample_target_pkg.sv
// Shared pedal SPI definitions: default sample width, sample word type and
// the target-side frame state encoding.
package spi_sample_target_pkg;

  localparam int SPI_WIDTH = 16;

  typedef logic [SPI_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_e;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_sample_target_if.sv
// SPI pins plus the tx/rx sample streams of the pedal's SPI target.
interface spi_sample_target_if #(
  parameter int WIDTH = 16
);
  logic             sclk_i;
  logic             cs_n_i;
  logic             mosi_i;
  logic             miso_o;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             underrun;
  logic             frame_err;

  modport master (
    output sclk_i, cs_n_i, mosi_i, tx_data, tx_valid,
    input  miso_o, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
  );

  modport slave (
    input  sclk_i, cs_n_i, mosi_i, tx_data, tx_valid,
    output miso_o, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus one delay stage, producing single-cycle
// rise/fall pulses for an asynchronous SPI pin.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       dly_reg;
  logic [1:0] fill_reg;
  logic       armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= {2{RESET_VAL}};
      dly_reg  <= RESET_VAL;
      fill_reg <= 2'd0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      dly_reg  <= sync_reg[1];
      if (fill_reg != 2'd3) begin
        fill_reg <= fill_reg + 2'd1;
      end
    end
  end

  // Suppress edges until every stage holds a real pin sample, so a pin that
  // differs from the reset value does not look like a transition.
  assign armed = (fill_reg == 2'd3);
  assign rise  = armed &  sync_reg[1] & ~dly_reg;
  assign fall  = armed & ~sync_reg[1] &  dly_reg;

endmodule

// File: rtl/spi_sample_target.sv
// Mode-0 SPI target, fully oversampled in the system clock: one WIDTH-bit
// word per chip-select frame, with a single-entry tx holding register.
module spi_sample_target
  import spi_sample_target_pkg::*;
#(
  parameter int               WIDTH     = SPI_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  spi_sample_target_if.slave bus
);

  localparam int         CW       = cnt_width(WIDTH);
  localparam logic [1:0] SYNC_RST = 2'b10;  // {cs_n, sclk} idle levels

  logic [1:0] pin_raw;
  logic [1:0] pin_rise;
  logic [1:0] pin_fall;

  assign pin_raw = {bus.cs_n_i, bus.sclk_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    spi_sync_edge #(
      .RESET_VAL(SYNC_RST[gi])
    ) u_sync (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .din (pin_raw[gi]),
      .rise(pin_rise[gi]),
      .fall(pin_fall[gi])
    );
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = pin_rise[0];
  assign sclk_fall = pin_fall[0];
  assign cs_rise   = pin_rise[1];
  assign cs_fall   = pin_fall[1];

  spi_state_e       state_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] tx_shift_reg;
  logic [WIDTH-1:0] rx_shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             tx_ready_reg;
  logic [1:0]       mosi_sync_reg;
  logic             miso_reg;
  logic             miso_oe_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_pend_reg;
  logic             rx_valid_reg;
  logic             underrun_reg;
  logic             frame_err_reg;
  logic             tx_fire;

  assign tx_fire = bus.tx_valid & tx_ready_reg;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      hold_reg      <= '0;
      tx_ready_reg  <= 1'b1;
      mosi_sync_reg <= 2'b00;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
      rx_data_reg   <= '0;
      rx_pend_reg   <= 1'b0;
      rx_valid_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      mosi_sync_reg <= {mosi_sync_reg[0], bus.mosi_i};
      underrun_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      rx_pend_reg   <= 1'b0;
      rx_valid_reg  <= rx_pend_reg;

      if (tx_fire) begin
        hold_reg     <= bus.tx_data;
        tx_ready_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
            miso_oe_reg <= 1'b1;
            if (!tx_ready_reg) begin
              tx_shift_reg <= hold_reg;
              miso_reg     <= hold_reg[WIDTH-1];
              tx_ready_reg <= 1'b1;
            end else if (tx_fire) begin
              // Word arriving exactly at frame start bypasses the holding register.
              tx_shift_reg <= bus.tx_data;
              miso_reg     <= bus.tx_data[WIDTH-1];
              tx_ready_reg <= 1'b1;
            end else begin
              tx_shift_reg <= IDLE_WORD;
              miso_reg     <= IDLE_WORD[WIDTH-1];
              underrun_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_reg     <= IDLE;
            miso_oe_reg   <= 1'b0;
            miso_reg      <= 1'b0;
            frame_err_reg <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], mosi_sync_reg[1]};
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == CW'(WIDTH - 1)) begin
              rx_data_reg <= {rx_shift_reg[WIDTH-2:0], mosi_sync_reg[1]};
              rx_pend_reg <= 1'b1;
              miso_reg    <= 1'b0;
              state_reg   <= DONE;
            end
          end else if (sclk_fall) begin
            tx_shift_reg <= tx_shift_reg << 1;
            miso_reg     <= tx_shift_reg[WIDTH-2];
          end
        end
        DONE: begin
          if (cs_rise) begin
            state_reg   <= IDLE;
            miso_oe_reg <= 1'b0;
            miso_reg    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.miso_o    = miso_reg;
  assign bus.miso_oe   = miso_oe_reg;
  assign bus.tx_ready  = tx_ready_reg;
  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_sample_target.sv
// Bench for spi_sample_target: an SPI master model at sclk = clk/8 driven
// with directed and random frames, checked against a frame-level model.
module tb_spi_sample_target;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_sample_target_if #(.WIDTH(W)) bus ();

  spi_sample_target #(
    .WIDTH    (W),
    .IDLE_WORD(16'h0000)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  // Frame-level reference state: queued tx words and the last full rx word.
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_model = '0;

  int rxv_n  = 0;
  int und_n  = 0;
  int ferr_n = 0;

  always @(negedge clk) begin
    if (bus.rx_valid)  rxv_n++;
    if (bus.underrun)  und_n++;
    if (bus.frame_err) ferr_n++;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    rxv_n  = 0;
    und_n  = 0;
    ferr_n = 0;
  endtask

  task automatic push_tx(input logic [W-1:0] w);
    @(negedge clk);
    expect_eq("tx_ready_idle", bus.tx_ready, 32'(tx_q.size() == 0));
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    tx_q.push_back(w);
    expect_eq("tx_ready_drop", bus.tx_ready, 0);
  endtask

  // Half an sclk period (4 clocks); optionally offers a tx word on the first clock.
  task automatic half_period(input bit do_load, input logic [W-1:0] w);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (do_load && c == 0) begin
        expect_eq("tx_ready_mid", bus.tx_ready, 32'(tx_q.size() == 0));
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
      end else begin
        bus.tx_valid = 1'b0;
      end
    end
    if (do_load) tx_q.push_back(w);
  endtask

  task automatic frame(input logic [W-1:0] word, input int nbits, input bit mid_load,
                       input logic [W-1:0] mid_word, input bit keep_cs);
    logic [W-1:0] exp_tx;
    logic [W-1:0] got_tx;
    bit           exp_under;
    exp_under = (tx_q.size() == 0);
    exp_tx    = exp_under ? 16'h0000 : tx_q.pop_front();
    got_tx    = '0;
    clear_counts();
    @(negedge clk);
    bus.mosi_i = word[W-1];
    bus.cs_n_i = 1'b0;
    half_period(1'b0, '0);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi_i = (i < W) ? word[W-1-i] : 1'b1;
      half_period(mid_load && i == 3, mid_word);
      expect_eq($sformatf("miso_b%0d", i), bus.miso_o, (i < W) ? 32'(exp_tx[W-1-i]) : 0);
      expect_eq($sformatf("miso_oe_b%0d", i), bus.miso_oe, 1);
      if (i < W) got_tx[W-1-i] = bus.miso_o;
      bus.sclk_i = 1'b1;
      half_period(1'b0, '0);
      bus.sclk_i = 1'b0;
    end
    bus.mosi_i = 1'b0;
    half_period(1'b0, '0);
    if (!keep_cs) begin
      bus.cs_n_i = 1'b1;
      half_period(1'b0, '0);
      half_period(1'b0, '0);
      if (nbits >= W) rx_model = word;
      expect_eq("rx_valid_cnt", rxv_n, (nbits >= W) ? 1 : 0);
      expect_eq("underrun_cnt", und_n, exp_under ? 1 : 0);
      expect_eq("frame_err_cnt", ferr_n, (nbits < W) ? 1 : 0);
      expect_eq("rx_data", bus.rx_data, rx_model);
      expect_eq("miso_oe_end", bus.miso_oe, 0);
      expect_eq("miso_end", bus.miso_o, 0);
      expect_eq("tx_ready_end", bus.tx_ready, 32'(tx_q.size() == 0));
      $display("frame mosi=%h bits=%0d miso=%h rx_data=%h rxv=%0d und=%0d ferr=%0d",
               word, nbits, got_tx, bus.rx_data, rxv_n, und_n, ferr_n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_miso"}, bus.miso_o, 0);
    expect_eq({tag, "_miso_oe"}, bus.miso_oe, 0);
    expect_eq({tag, "_tx_ready"}, bus.tx_ready, 1);
    expect_eq({tag, "_rx_data"}, bus.rx_data, 0);
    expect_eq({tag, "_rx_valid"}, bus.rx_valid, 0);
    expect_eq({tag, "_underrun"}, bus.underrun, 0);
    expect_eq({tag, "_frame_err"}, bus.frame_err, 0);
  endtask

  initial begin
    logic [W-1:0] rw;
    logic [W-1:0] rm;
    int           nb;
    bit           ml;
    bus.sclk_i   = 1'b0;
    bus.cs_n_i   = 1'b1;
    bus.mosi_i   = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_reset_outputs("post_rst");

    // Loopback, underrun, short, overlong, back-to-back.
    push_tx(16'hA5C3);
    frame(16'h1234, 16, 1'b0, '0, 1'b0);
    frame(16'hFFFF, 16, 1'b0, '0, 1'b0);
    frame(16'h6B2E, 9, 1'b0, '0, 1'b0);
    frame(16'h8001, 20, 1'b0, '0, 1'b0);
    push_tx(16'h0F0F);
    frame(16'h1111, 16, 1'b1, 16'hF0F0, 1'b0);
    frame(16'h2222, 16, 1'b0, '0, 1'b0);

    // Reset in the middle of a frame, with cs_n still low afterwards.
    push_tx(16'h3C3C);
    frame(16'hABCD, 5, 1'b0, '0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    rx_model = '0;
    clear_counts();
    repeat (12) @(negedge clk);
    expect_eq("held_low_miso_oe", bus.miso_oe, 0);
    expect_eq("held_low_underrun", und_n, 0);
    bus.cs_n_i = 1'b1;
    repeat (8) @(negedge clk);
    push_tx(16'h5AA5);
    frame(16'hC0DE, 16, 1'b0, '0, 1'b0);

    // Random frames: optional tx queueing, random lengths, optional mid-frame load.
    for (int n = 0; n < 30; n++) begin
      rw = W'($urandom);
      rm = W'($urandom);
      if (tx_q.size() == 0 && $urandom_range(0, 1) == 1) push_tx(W'($urandom));
      nb = ($urandom_range(0, 1) == 1) ? W : int'($urandom_range(0, 22));
      ml = ($urandom_range(0, 3) == 0);
      frame(rw, nb, ml, rm, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
